// File: rtl/count_pkg.sv
// Shared types and constants for the count capture FIFO block.
package count_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } cap_state_e;

    localparam int DROP_CNT_W = 16;
    localparam int COUNT_W    = 32;

endpackage

// File: rtl/count_fifo_mem.sv
// Register-file FIFO with wrap-bit pointers; head is presented combinationally.
module count_fifo_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push_acc;
    logic             pop_acc;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A push into a full FIFO only lands when the head leaves in the same cycle.
    assign pop_acc  = pop && !empty;
    assign push_acc = push && (!full || pop_acc);

    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_acc) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop_acc)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_acc) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/count_capture_fifo.sv
// Captures a free-running count into a FIFO between start and stop pulses.
// Optional step checking is enabled with COUNT_CAPTURE_STEP_CHECK_EN.
module count_capture_fifo
    import count_pkg::*;
#(
    parameter int WIDTH = COUNT_W,
    parameter int DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      cnt_in,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic [DROP_CNT_W-1:0] drop_count,
    output logic                  busy,
    output logic                  step_err,
    output logic [1:0]            dbg_state
);

    // Handshake: a sample leaves when out_valid && out_ready on a rising edge;
    // out_valid never depends on out_ready.

    cap_state_e state_q;
    cap_state_e state_d;
    logic       push;
    logic       pop;
    logic       start_acc;

    assign push       = (state_q == CAPTURE);
    assign out_valid  = !fifo_empty;
    assign pop        = out_valid && out_ready;
    assign start_acc  = (state_q == IDLE) && start;
    assign busy       = (state_q == CAPTURE) || (state_q == DRAIN);
    assign dbg_state  = state_q;

    count_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .wr_data (cnt_in),
        .rd_data (out_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)      state_d = CAPTURE;
            CAPTURE: if (stop)       state_d = DRAIN;
            DRAIN:   if (fifo_empty) state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_count <= '0;
        end else if (start_acc) begin
            drop_count <= '0;
        end else if (push && fifo_full && !pop && (drop_count != '1)) begin
            drop_count <= drop_count + DROP_CNT_W'(1);
        end
    end

`ifdef COUNT_CAPTURE_STEP_CHECK_EN
    logic [WIDTH-1:0] prev_q;
    logic             have_prev_q;
    logic             step_err_q;

    // Every capture cycle is tracked, dropped samples included, so a full
    // FIFO cannot hide a skip in the upstream counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q      <= '0;
            have_prev_q <= 1'b0;
            step_err_q  <= 1'b0;
        end else if (start_acc) begin
            have_prev_q <= 1'b0;
            step_err_q  <= 1'b0;
        end else if (push) begin
            prev_q      <= cnt_in;
            have_prev_q <= 1'b1;
            if (have_prev_q && (cnt_in != prev_q + WIDTH'(1))) step_err_q <= 1'b1;
        end
    end

    assign step_err = step_err_q;
`else
    assign step_err = 1'b0;
`endif

endmodule

// File: tb/tb_count_capture_fifo.sv
// Directed self-checking bench for count_capture_fifo (WIDTH=32, DEPTH=8).
module tb_count_capture_fifo;

    localparam int W = 32;
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;

`ifdef COUNT_CAPTURE_STEP_CHECK_EN
    localparam logic STEP_ERR_JUMP = 1'b1;
`else
    localparam logic STEP_ERR_JUMP = 1'b0;
`endif

    logic         clk;
    logic         reset;
    logic [W-1:0] cnt_in;
    logic         start;
    logic         stop;
    logic         out_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         fifo_full;
    logic         fifo_empty;
    logic [15:0]  drop_count;
    logic         busy;
    logic         step_err;
    logic [1:0]   dbg_state;

    int n_checks;
    int n_errors;

    count_capture_fifo #(.WIDTH(W), .DEPTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .cnt_in     (cnt_in),
        .start      (start),
        .stop       (stop),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .drop_count (drop_count),
        .busy       (busy),
        .step_err   (step_err),
        .dbg_state  (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, let the edge pass, settle 1 time unit after it.
    task automatic cyc(input logic [W-1:0] c, input logic s, input logic p, input logic r);
        cnt_in    = c;
        start     = s;
        stop      = p;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b0;
        cnt_in    = '0;
        start     = 1'b0;
        stop      = 1'b0;
        out_ready = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", W'(out_valid), 0);
        check("rst_empty", W'(fifo_empty), 1);
        check("rst_full", W'(fifo_full), 0);
        check("rst_data", out_data, 0);
        check("rst_drop", W'(drop_count), 0);
        check("rst_busy", W'(busy), 0);
        check("rst_step", W'(step_err), 0);
        check("rst_state", W'(dbg_state), W'(ST_IDLE));
        reset = 1'b1;

        // Streaming capture with out_ready high
        cyc(4, 0, 0, 1);
        cyc(5, 1, 0, 1);
        check("t1_busy", W'(busy), 1);
        check("t1_novalid", W'(out_valid), 0);
        cyc(6, 0, 0, 1);
        check("t1_valid", W'(out_valid), 1);
        check("t1_d6", out_data, 6);
        cyc(7, 0, 0, 1);
        check("t1_d7", out_data, 7);
        cyc(8, 0, 0, 1);
        check("t1_d8", out_data, 8);
        cyc(9, 0, 1, 1);
        check("t1_d9", out_data, 9);
        check("t1_drain", W'(dbg_state), W'(ST_DRAIN));
        cyc(10, 0, 0, 1);
        check("t1_empty", W'(fifo_empty), 1);
        check("t1_still_drain", W'(dbg_state), W'(ST_DRAIN));
        cyc(11, 0, 0, 1);
        check("t1_idle", W'(dbg_state), W'(ST_IDLE));
        check("t1_step", W'(step_err), 0);

        // Backpressured 12-cycle capture: 8 stored, 4 dropped
        cyc(100, 1, 0, 0);
        for (int k = 1; k <= 12; k++) begin
            cyc(W'(100 + k), 1'b0, (k == 12), 1'b0);
            if (k == 7) check("t2_notfull7", W'(fifo_full), 0);
            if (k == 8) check("t2_full8", W'(fifo_full), 1);
        end
        check("t2_drop4", W'(drop_count), 4);
        check("t2_head", out_data, 101);
        check("t2_step", W'(step_err), 0);
        cyc(0, 0, 0, 1);
        check("t2_d102", out_data, 102);

        // start during DRAIN is ignored; drain the rest
        cyc(0, 1, 0, 1);
        check("t2_start_ign", W'(dbg_state), W'(ST_DRAIN));
        check("t2_drop_kept", W'(drop_count), 4);
        for (int i = 0; i < 6; i++) begin
            check("t2_drain_seq", out_data, W'(103 + i));
            cyc(0, 0, 0, 1);
        end
        check("t2_empty", W'(fifo_empty), 1);
        cyc(0, 0, 0, 1);
        check("t2_idle", W'(dbg_state), W'(ST_IDLE));
        check("t2_busy0", W'(busy), 0);

        // Push and pop together while full
        cyc(200, 1, 0, 0);
        check("t3_drop_clr", W'(drop_count), 0);
        for (int k = 1; k <= 8; k++) cyc(W'(200 + k), 0, 0, 0);
        check("t3_full", W'(fifo_full), 1);
        cyc(209, 0, 0, 1);
        check("t3_nodrop", W'(drop_count), 0);
        check("t3_still_full", W'(fifo_full), 1);
        check("t3_head", out_data, 202);
        cyc(210, 0, 1, 0);
        check("t3_drop1", W'(drop_count), 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
        check("t3_head5", out_data, 205);

        // Asynchronous reset with 5 entries queued
        reset = 1'b0;
        #1;
        check("t4_valid0", W'(out_valid), 0);
        check("t4_empty1", W'(fifo_empty), 1);
        check("t4_drop0", W'(drop_count), 0);
        check("t4_busy0", W'(busy), 0);
        check("t4_data0", out_data, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 1);
            check("t4_no_hs", W'(out_valid), 0);
        end

        // Wrap-around increment, then a deliberate jump
        cyc(0, 1, 0, 1);
        cyc(32'hFFFF_FFFE, 0, 0, 1);
        cyc(32'hFFFF_FFFF, 0, 0, 1);
        cyc(32'h0000_0000, 0, 0, 1);
        cyc(32'h0000_0001, 0, 1, 1);
        check("t5_wrap_ok", W'(step_err), 0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        check("t5_idle", W'(dbg_state), W'(ST_IDLE));
        cyc(0, 1, 0, 1);
        cyc(32'h10, 0, 0, 1);
        cyc(32'h13, 0, 1, 1);
        check("t5_jump", W'(step_err), W'(STEP_ERR_JUMP));
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 1, 0, 1);
        check("t5_clr", W'(step_err), 0);
        cyc(5, 0, 1, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        check("t5_end_idle", W'(dbg_state), W'(ST_IDLE));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/count_capture_fifo.md
COUNT_CAPTURE_FIFO -- requirements
Module: count_capture_fifo

Interface
REQ-001 Parameter WIDTH: default 32; bit width of the sampled count and of out_data.
REQ-002 Parameter DEPTH: default 8; FIFO entries, power of two, at least 2.
REQ-003 clk  input  1  single clock; every flop samples on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low; reset asserts when low.
REQ-005 cnt_in  input  WIDTH  count value from the upstream incrementing flip-flop.
REQ-006 start  input  1  single-cycle pulse that begins a capture session.
REQ-007 stop  input  1  single-cycle pulse that ends the capture session.
REQ-008 out_ready  input  1  downstream consumer accepts out_data this cycle.
REQ-009 out_valid  output  1  out_data holds the FIFO head.
REQ-010 out_data  output  WIDTH  oldest captured sample.
REQ-011 fifo_full / fifo_empty  output  1 each  FIFO occupancy flags.
REQ-012 drop_count  output  16  samples lost while the FIFO was full; saturates at 0xFFFF.
REQ-013 busy  output  1  high in the CAPTURE and DRAIN states.
REQ-014 step_err  output  1  sticky non-increment flag.

Function
REQ-015 The FSM shall have states IDLE, CAPTURE and DRAIN.
REQ-016 Transitions shall be:
- IDLE -> CAPTURE on start; stop is ignored in IDLE.
- CAPTURE -> DRAIN on stop; start is ignored in CAPTURE.
- DRAIN -> IDLE once the FIFO is empty; start and stop are ignored in DRAIN.
REQ-017 While the registered state is CAPTURE, the block shall push cnt_in every cycle; the first pushed sample is the cnt_in of the cycle after start was sampled.
REQ-018 On the cycle stop is sampled, the block shall still push cnt_in (that cycle's state is CAPTURE), and no pushes shall occur after it.
REQ-019 The pop handshake shall be out_valid && out_ready; out_valid shall equal !fifo_empty.
REQ-020 Latency: a sample pushed in cycle N shall be visible on out_data in cycle N+1 at the earliest.
REQ-021 A push while full with no pop in the same cycle shall be dropped: FIFO contents unchanged, drop_count incremented (saturating).
REQ-022 A push and a pop in the same cycle while full shall both be accepted, with no drop; a push and a pop while empty shall push only.
REQ-023 Read and write pointers shall wrap modulo DEPTH; fifo_full and fifo_empty shall come from an extra pointer wrap bit.
REQ-024 start accepted from IDLE shall clear drop_count and step_err; FIFO contents are already empty at that point.
REQ-025 cnt_in shall be treated as an unsigned value with modulo-2^WIDTH arithmetic, so that 0xFFFFFFFF followed by 0x00000000 is a legal increment.

Reset
REQ-026 Reset low shall immediately force: state IDLE; FIFO pointers 0; out_valid 0; out_data 0; fifo_empty 1; fifo_full 0; drop_count 0; busy 0; step_err 0.
REQ-027 Reset asserted mid-session shall discard all FIFO contents, with no further output handshakes until a new start.
REQ-028 Reset deassertion shall take effect at the next rising clk edge.

Configuration
REQ-029 With COUNT_CAPTURE_STEP_CHECK_EN defined, the block shall hold the previous pushed-cycle cnt_in, including samples that were dropped.
REQ-030 With the macro defined, each CAPTURE cycle after the first shall set step_err if cnt_in != prev + 1 (mod 2^WIDTH); step_err shall stay set until reset or an accepted start.
REQ-031 Without the macro, step_err shall be tied to 0 and no prev register shall exist.

Structure
REQ-032 The shared package count_pkg shall hold:
- the state enum cap_state_e (IDLE, CAPTURE, DRAIN);
- the localparam DROP_CNT_W = 16;
- the default width constant COUNT_W = 32.
REQ-033 Storage and pointers shall live in one sub-module, count_fifo_mem (parameterised WIDTH and DEPTH, with push/pop/full/empty); the FSM, drop counter and step check shall live in the top level.

Verification
REQ-034 Reset release, then start at cycle 2 with cnt_in incrementing from 5 and out_ready=1 -> out_data sequence is 6, 7, 8, ..., out_valid first high one cycle after the first push, and step_err=0.
REQ-035 out_ready=0 with a 12-cycle capture and DEPTH=8 -> fifo_full after 8 pushes, drop_count=4, and out_data=first sample after out_ready rises.
REQ-036 FIFO full with out_ready=1 and a push in the same cycle -> no drop, and occupancy stays 8.
REQ-037 cnt_in sequence 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1 -> step_err=0; inject a jump 0x10 -> 0x13 -> step_err=1 (macro on), and step_err=0 (macro off).
REQ-038 stop, then drain 3 entries with out_ready=1 -> state returns to IDLE one cycle after fifo_empty, busy=0, and a start issued during DRAIN is ignored.
REQ-039 Reset asserted with 5 entries queued -> immediate out_valid=0, fifo_empty=1 and drop_count=0, with no output handshakes until the next start.
